// File: rtl/frame_arbiter_pkg.sv
// Shared types and helpers for the frame arbiter and its round-robin picker.
package frame_arbiter_pkg;

  // Number of requesters sharing the sample counter.
  localparam int NREQ = 2;

  // Frame sequencer states; prefixed so they never collide with the GAP parameter.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // One-hot vector with bit idx set.
  function automatic logic [NREQ-1:0] onehot(input logic idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/frame_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational choice, registered "last winner" pointer.
module rr_arb2
  import frame_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            take,
  output logic [NREQ-1:0] pick
);

  // Index of the requester granted most recently; reset value makes requester 0 preferred.
  logic last_reg;
  logic win_idx;

  // Pointer moves only when the picked requester is actually granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_reg <= 1'b1;
    end else if (take) begin
      last_reg <= win_idx;
    end
  end

  // Lone requester wins outright; on contention the one not granted last wins.
  always_comb begin
    win_idx = 1'b0;
    pick    = '0;
    case (req)
      2'b01:   win_idx = 1'b0;
      2'b10:   win_idx = 1'b1;
      2'b11:   win_idx = ~last_reg;
      default: win_idx = 1'b0;
    endcase
    if (req != '0) begin
      pick = onehot(win_idx);
    end
  end

endmodule

// File: rtl/frame_arbiter.sv
// Frame sequencer: grants the shared sample counter to one requester per frame,
// counts NDATA samples, then idles GAP enabled cycles before re-arbitrating.
module frame_arbiter
  import frame_arbiter_pkg::*;
#(
  parameter int NDATA     = 128,
  parameter int NDATA_LOG = $clog2(NDATA),
  parameter int GAP       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      gnt,
  output logic [NDATA_LOG-1:0] cnt,
  output logic                 valid,
  output logic                 first,
  output logic                 last,
  output logic [NREQ-1:0]      done,
  output logic                 busy
);

  localparam int GAPW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [NDATA_LOG-1:0] CNT_LAST = NDATA_LOG'(NDATA - 1);
  localparam logic [GAPW-1:0] GAP_LOAD = GAPW'((GAP > 0) ? (GAP - 1) : 0);

  state_t                state_reg, state_next;
  logic [NDATA_LOG-1:0]  cnt_reg, cnt_next;
  logic [NREQ-1:0]       gnt_reg, gnt_next;
  logic                  valid_reg, valid_next;
  logic [NREQ-1:0]       done_reg, done_next;
  logic [GAPW-1:0]       gap_reg, gap_next;
  logic [NREQ-1:0]       pick;
  logic                  take;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .take (take),
    .pick (pick)
  );

  // State and datapath registers; done follows done_next even when stalled so it self-clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      gnt_reg   <= '0;
      valid_reg <= 1'b0;
      done_reg  <= '0;
      gap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
      gap_reg   <= gap_next;
    end
  end

  // Next-state logic; everything except done holds while ena is low.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gnt_next   = gnt_reg;
    valid_next = valid_reg;
    gap_next   = gap_reg;
    done_next  = '0;
    take       = 1'b0;
    if (ena) begin
      case (state_reg)
        S_IDLE: begin
          if (req != '0) begin
            state_next = S_RUN;
            gnt_next   = pick;
            cnt_next   = '0;
            valid_next = 1'b1;
            take       = 1'b1;
          end
        end
        S_RUN: begin
          if (cnt_reg == CNT_LAST) begin
            // gnt_reg still names the finishing requester here.
            done_next  = gnt_reg;
            gnt_next   = '0;
            cnt_next   = '0;
            valid_next = 1'b0;
            gap_next   = GAP_LOAD;
            state_next = (GAP == 0) ? S_IDLE : S_GAP;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_reg == '0) begin
            state_next = S_IDLE;
          end else begin
            gap_next = gap_reg - 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign gnt   = gnt_reg;
  assign cnt   = cnt_reg;
  assign valid = valid_reg;
  assign done  = done_reg;
  assign first = valid_reg && (cnt_reg == '0);
  assign last  = valid_reg && (cnt_reg == CNT_LAST);
  assign busy  = (state_reg != S_IDLE);

endmodule

// File: tb/tb_frame_arbiter.sv
// Directed bench: NDATA=8/GAP=2 instance for the main scenarios, NDATA=4/GAP=0 for the no-gap case.
module tb_frame_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NDATA=8, GAP=2
  logic       rst, ena;
  logic [1:0] req, gnt, done;
  logic [2:0] cnt;
  logic       valid, first, last, busy;

  frame_arbiter #(.NDATA(8), .GAP(2)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .gnt(gnt), .cnt(cnt),
    .valid(valid), .first(first), .last(last), .done(done), .busy(busy)
  );

  // Instance B: NDATA=4, GAP=0
  logic       rst_b, ena_b;
  logic [1:0] req_b, gnt_b, done_b;
  logic [1:0] cnt_b;
  logic       valid_b, first_b, last_b, busy_b;

  frame_arbiter #(.NDATA(4), .GAP(0)) u_dut_b (
    .clk(clk), .rst(rst_b), .ena(ena_b), .req(req_b), .gnt(gnt_b), .cnt(cnt_b),
    .valid(valid_b), .first(first_b), .last(last_b), .done(done_b), .busy(busy_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_g;

  initial begin
    rst = 1'b0; ena = 1'b1; req = 2'b00;
    rst_b = 1'b0; ena_b = 1'b0; req_b = 2'b00;

    // Reset state
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Single frame for requester 0
    req = 2'b01;
    tick();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_first", 32'(first), 1);
    chk("t1_cnt0", 32'(cnt), 0);
    req = 2'b00;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t1_cnt", 32'(cnt), 32'(i));
    end
    chk("t1_last", 32'(last), 1);
    tick();
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_valid0", 32'(valid), 0);
    chk("t1_gnt0", 32'(gnt), 0);
    chk("t1_busy_gap", 32'(busy), 1);
    tick();
    chk("t1_done_clr", 32'(done), 0);
    chk("t1_busy_gap2", 32'(busy), 1);
    tick();
    chk("t1_idle", 32'(busy), 0);

    // Round-robin: requester 0 won last, so requester 1 leads; period 11 cycles
    req = 2'b11;
    exp_g = 2'b10;
    for (int f = 0; f < 4; f++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(exp_g));
      chk("rr_first", 32'(first), 1);
      repeat (7) tick();
      chk("rr_last", 32'(last), 1);
      tick();
      chk("rr_done", 32'(done), 32'(exp_g));
      repeat (2) tick();
      exp_g = ~exp_g;
    end

    // Stall at cnt=4, then done clears even with ena low
    req = 2'b01;
    tick();
    chk("st_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    repeat (4) tick();
    chk("st_cnt4", 32'(cnt), 4);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_cnt", 32'(cnt), 4);
      chk("st_hold_valid", 32'(valid), 1);
      chk("st_hold_gnt", 32'(gnt), 32'h1);
    end
    ena = 1'b1;
    tick();
    chk("st_cnt5", 32'(cnt), 5);
    repeat (2) tick();
    chk("st_last", 32'(last), 1);
    tick();
    chk("st_done", 32'(done), 32'h1);
    ena = 1'b0;
    tick();
    chk("st_done_clr_noena", 32'(done), 0);
    chk("st_gap_frozen", 32'(busy), 1);
    ena = 1'b1;
    repeat (2) tick();
    chk("st_idle", 32'(busy), 0);

    // Request drop mid-frame
    req = 2'b10;
    tick();
    chk("rd_gnt", 32'(gnt), 32'h2);
    repeat (2) tick();
    chk("rd_cnt2", 32'(cnt), 2);
    req = 2'b00;
    repeat (5) tick();
    chk("rd_cnt7", 32'(cnt), 7);
    tick();
    chk("rd_done", 32'(done), 32'h2);
    repeat (2) tick();
    chk("rd_idle", 32'(busy), 0);

    // Async reset mid-frame; pointer last pointed at requester 0 before the reset
    req = 2'b11;
    tick();
    chk("ar_gnt_pre", 32'(gnt), 32'h1);
    repeat (5) tick();
    chk("ar_cnt5", 32'(cnt), 5);
    #2 rst = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 0);
    chk("ar_valid", 32'(valid), 0);
    chk("ar_cnt", 32'(cnt), 0);
    chk("ar_done", 32'(done), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("ar_regrant", 32'(gnt), 32'h1);
    req = 2'b00;

    // GAP=0, NDATA=4: done and IDLE on the same edge, 5-cycle period
    rst_b = 1'b1; ena_b = 1'b1; req_b = 2'b11;
    tick();
    chk("g0_gnt", 32'(gnt_b), 32'h1);
    chk("g0_first", 32'(first_b), 1);
    repeat (3) tick();
    chk("g0_last", 32'(last_b), 1);
    chk("g0_cnt3", 32'(cnt_b), 3);
    tick();
    chk("g0_done", 32'(done_b), 32'h1);
    chk("g0_busy", 32'(busy_b), 0);
    chk("g0_valid", 32'(valid_b), 0);
    tick();
    chk("g0_gnt2", 32'(gnt_b), 32'h2);
    chk("g0_first2", 32'(first_b), 1);
    chk("g0_done_clr", 32'(done_b), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
